// File: rtl/nibble_arb_pkg.sv
// Shared definitions for the nibble round-robin arbiter: state encoding,
// default sizing and the index/counter width derivations.
package nibble_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_DATA_W    = 4;
  localparam int unsigned DEF_MAX_BURST = 4;

  // Width needed to index n requesters (at least one bit).
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width needed to count 0..b beats.
  function automatic int unsigned cnt_w(input int unsigned b);
    return $clog2(b + 1);
  endfunction

  localparam int unsigned DEF_PTR_W = ptr_w(DEF_NUM_REQ);
  localparam int unsigned DEF_CNT_W = cnt_w(DEF_MAX_BURST);

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping around.
module rr_pick
  import nibble_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned PTR_W   = ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   winner_c,
  output logic               any_req_c
);

  // Scan offsets high to low so the smallest offset from ptr wins last.
  always_comb begin
    winner_c = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      logic [PTR_W-1:0] idx;
      idx = PTR_W'((unsigned'(32'(ptr)) + unsigned'(32'(i))) % NUM_REQ);
      if (req[idx]) winner_c = idx;
    end
  end

  // Any pending request at all.
  always_comb begin
    any_req_c = |req;
  end

endmodule

// File: rtl/nibble_rr_arbiter.sv
// Round-robin arbiter sharing one nibble bus among NUM_REQ requesters.
// Bursts up to MAX_BURST beats per grant under READY_IN back-pressure.
// Optional: define NIBBLE_ARB_PARITY_EN to add the PARITY_OUT even-parity output.
module nibble_rr_arbiter
  import nibble_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic                      CLK,
  input  logic                      RESET_L,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [NUM_REQ*DATA_W-1:0] DATA_IN,
  input  logic                      READY_IN,
  output logic [NUM_REQ-1:0]        GNT,
  output logic [DATA_W-1:0]         DATA_OUT,
  output logic                      VALID_OUT,
  output logic                      BUSY
`ifdef NIBBLE_ARB_PARITY_EN
  ,
  output logic                      PARITY_OUT
`endif
);

  localparam int unsigned PTR_W = ptr_w(NUM_REQ);
  localparam int unsigned CNT_W = cnt_w(MAX_BURST);

  state_e             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [CNT_W-1:0]   beat_cnt;
  logic [PTR_W-1:0]   winner_c;
  logic               any_req_c;
  logic [DATA_W-1:0]  data_sel_c;
  logic               xfer_c;
  logic               last_beat_c;
  logic               release_c;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req       (REQ),
    .ptr       (ptr),
    .winner_c  (winner_c),
    .any_req_c (any_req_c)
  );

  // Select the owner's data slice.
  always_comb begin
    data_sel_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == PTR_W'(i)) data_sel_c = DATA_IN[i*DATA_W +: DATA_W];
    end
  end

  // Transfer and release conditions while granted.
  always_comb begin
    xfer_c      = GNT[owner] & REQ[owner] & READY_IN;
    last_beat_c = xfer_c & (beat_cnt == CNT_W'(MAX_BURST - 1));
    release_c   = ~REQ[owner] | last_beat_c;
  end

  // Arbitration FSM with registered grant, data and status outputs.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      owner      <= '0;
      beat_cnt   <= '0;
      GNT        <= '0;
      DATA_OUT   <= '0;
      VALID_OUT  <= 1'b0;
      BUSY       <= 1'b0;
`ifdef NIBBLE_ARB_PARITY_EN
      PARITY_OUT <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          VALID_OUT <= 1'b0;
          if (any_req_c) begin
            GNT      <= NUM_REQ'(1) << winner_c;
            owner    <= winner_c;
            beat_cnt <= '0;
            BUSY     <= 1'b1;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          VALID_OUT <= xfer_c;
          if (xfer_c) begin
            DATA_OUT   <= data_sel_c;
            beat_cnt   <= beat_cnt + CNT_W'(1);
`ifdef NIBBLE_ARB_PARITY_EN
            PARITY_OUT <= ^data_sel_c;
`endif
          end
          if (release_c) begin
            GNT   <= '0;
            BUSY  <= 1'b0;
            state <= ST_IDLE;
            ptr   <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          GNT   <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_rr_arbiter.sv
// Directed self-checking bench: instance a uses MAX_BURST=4, instance b MAX_BURST=1.
module tb_nibble_rr_arbiter;

  logic        CLK;
  logic        RESET_L;

  logic [3:0]  req_a;
  logic [15:0] data_a;
  logic        ready_a;
  logic [3:0]  gnt_a;
  logic [3:0]  dout_a;
  logic        valid_a;
  logic        busy_a;

  logic [3:0]  req_b;
  logic [15:0] data_b;
  logic        ready_b;
  logic [3:0]  gnt_b;
  logic [3:0]  dout_b;
  logic        valid_b;
  logic        busy_b;

`ifdef NIBBLE_ARB_PARITY_EN
  logic        par_a;
  logic        par_b;
`endif

  int checks   = 0;
  int failures = 0;

  nibble_rr_arbiter #(.NUM_REQ(4), .DATA_W(4), .MAX_BURST(4)) u_dut_a (
    .CLK       (CLK),
    .RESET_L   (RESET_L),
    .REQ       (req_a),
    .DATA_IN   (data_a),
    .READY_IN  (ready_a),
    .GNT       (gnt_a),
    .DATA_OUT  (dout_a),
    .VALID_OUT (valid_a),
    .BUSY      (busy_a)
`ifdef NIBBLE_ARB_PARITY_EN
    ,
    .PARITY_OUT(par_a)
`endif
  );

  nibble_rr_arbiter #(.NUM_REQ(4), .DATA_W(4), .MAX_BURST(1)) u_dut_b (
    .CLK       (CLK),
    .RESET_L   (RESET_L),
    .REQ       (req_b),
    .DATA_IN   (data_b),
    .READY_IN  (ready_b),
    .GNT       (gnt_b),
    .DATA_OUT  (dout_b),
    .VALID_OUT (valid_b),
    .BUSY      (busy_b)
`ifdef NIBBLE_ARB_PARITY_EN
    ,
    .PARITY_OUT(par_b)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one active edge and settle past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [3:0] bp_ready [6];
  logic [3:0] bp_valid [6];
  logic [3:0] bp_data  [6];
  logic [3:0] bp_gnt   [6];
  logic [3:0] burst    [4];
  int         beats;

  initial begin
    RESET_L = 1'b0;
    req_a = 4'b1111; data_a = '0; ready_a = 1'b1;
    req_b = 4'b0000; data_b = '0; ready_b = 1'b1;
    tick(); tick();

    // Reset holds everything low despite requests.
    check("rst_gnt",   32'(gnt_a),   32'h0);
    check("rst_valid", 32'(valid_a), 32'h0);
    check("rst_data",  32'(dout_a),  32'h0);
    check("rst_busy",  32'(busy_a),  32'h0);

    req_a = 4'b0000;
    RESET_L = 1'b1;
    tick();
    check("idle_gnt", 32'(gnt_a), 32'h0);

    // Single requester 2, burst A,B,C,D then regrant for E.
    req_a = 4'b0100;
    data_a[8 +: 4] = 4'hA;
    tick();
    check("single_gnt",   32'(gnt_a),   32'h4);
    check("single_busy",  32'(busy_a),  32'h1);
    check("single_valid0",32'(valid_a), 32'h0);
    burst[0] = 4'hA; burst[1] = 4'hB; burst[2] = 4'hC; burst[3] = 4'hD;
    for (int k = 0; k < 4; k++) begin
      data_a[8 +: 4] = burst[k];
      tick();
      check("burst_valid", 32'(valid_a), 32'h1);
      check("burst_data",  32'(dout_a),  32'(burst[k]));
      check("burst_gnt",   32'(gnt_a),   (k == 3) ? 32'h0 : 32'h4);
    end
    data_a[8 +: 4] = 4'hE;
    tick();
    check("regrant_gnt",   32'(gnt_a),   32'h4);
    check("regrant_valid", 32'(valid_a), 32'h0);
    tick();
    check("regrant_data",  32'(dout_a),  32'hE);
    check("regrant_valid1",32'(valid_a), 32'h1);
    req_a = 4'b0000;
    tick();
    check("drop_gnt",   32'(gnt_a),   32'h0);
    check("drop_valid", 32'(valid_a), 32'h0);
    check("drop_hold",  32'(dout_a),  32'hE);
    check("drop_busy",  32'(busy_a),  32'h0);

    // Back-pressure on owner 1 (ptr=3, search wraps to 1).
    req_a = 4'b0010;
    tick();
    check("bp_gnt", 32'(gnt_a), 32'h2);
    bp_ready[0] = 4'd1; bp_valid[0] = 4'd1; bp_data[0] = 4'h1; bp_gnt[0] = 4'h2;
    bp_ready[1] = 4'd0; bp_valid[1] = 4'd0; bp_data[1] = 4'h1; bp_gnt[1] = 4'h2;
    bp_ready[2] = 4'd0; bp_valid[2] = 4'd0; bp_data[2] = 4'h1; bp_gnt[2] = 4'h2;
    bp_ready[3] = 4'd1; bp_valid[3] = 4'd1; bp_data[3] = 4'h4; bp_gnt[3] = 4'h2;
    bp_ready[4] = 4'd1; bp_valid[4] = 4'd1; bp_data[4] = 4'h5; bp_gnt[4] = 4'h2;
    bp_ready[5] = 4'd1; bp_valid[5] = 4'd1; bp_data[5] = 4'h6; bp_gnt[5] = 4'h0;
    beats = 0;
    for (int k = 0; k < 6; k++) begin
      ready_a = bp_ready[k][0];
      data_a[4 +: 4] = 4'(k + 1);
      tick();
      if (valid_a === 1'b1) beats++;
      check("bp_valid", 32'(valid_a), 32'(bp_valid[k]));
      check("bp_data",  32'(dout_a),  32'(bp_data[k]));
      check("bp_gnt",   32'(gnt_a),   32'(bp_gnt[k]));
    end
    check("bp_beats", 32'(beats), 32'd4);
    req_a = 4'b0000;
    ready_a = 1'b1;
    tick();
    check("bp_idle_valid", 32'(valid_a), 32'h0);

    // Early release of owner 3 after two beats; ptr wraps to 0.
    req_a = 4'b1000;
    tick();
    check("early_gnt", 32'(gnt_a), 32'h8);
    data_a[12 +: 4] = 4'h7;
    tick();
    data_a[12 +: 4] = 4'h8;
    tick();
    check("early_beat2", 32'(dout_a), 32'h8);
    req_a = 4'b0011;
    tick();
    check("early_rel_gnt",   32'(gnt_a),   32'h0);
    check("early_rel_valid", 32'(valid_a), 32'h0);
    check("early_rel_hold",  32'(dout_a),  32'h8);
    tick();
    check("wrap_gnt", 32'(gnt_a), 32'h1);

    // Asynchronous reset in the middle of a burst.
    data_a[0 +: 4] = 4'h9;
    tick();
    check("mid_valid", 32'(valid_a), 32'h1);
    check("mid_data",  32'(dout_a),  32'h9);
    #2;
    RESET_L = 1'b0;
    #1;
    check("arst_gnt",   32'(gnt_a),   32'h0);
    check("arst_valid", 32'(valid_a), 32'h0);
    check("arst_data",  32'(dout_a),  32'h0);
    check("arst_busy",  32'(busy_a),  32'h0);
    req_a = 4'b0000;
    tick();
    RESET_L = 1'b1;
    tick();

    // Round-robin rotation with single-beat grants.
    req_b = 4'b1111;
    data_b = 16'h4321;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_gnt",       32'(gnt_b),   32'(4'b0001 << (k % 4)));
      check("rr_gap_valid", 32'(valid_b), 32'h0);
      tick();
      check("rr_valid",     32'(valid_b), 32'h1);
      check("rr_data",      32'(dout_b),  32'((k % 4) + 1));
      check("rr_rel_gnt",   32'(gnt_b),   32'h0);
    end
    req_b = 4'b0000;
    tick();

    // Forward 7 then 3 on requester 0, then stall.
    req_a = 4'b0001;
    tick();
    data_a[0 +: 4] = 4'h7;
    tick();
    check("par7_data", 32'(dout_a), 32'h7);
`ifdef NIBBLE_ARB_PARITY_EN
    check("par7_parity", 32'(par_a), 32'h1);
`endif
    data_a[0 +: 4] = 4'h3;
    tick();
    check("par3_data", 32'(dout_a), 32'h3);
`ifdef NIBBLE_ARB_PARITY_EN
    check("par3_parity", 32'(par_a), 32'h0);
`endif
    ready_a = 1'b0;
    data_a[0 +: 4] = 4'h1;
    tick();
    check("stall_valid", 32'(valid_a), 32'h0);
    check("stall_hold",  32'(dout_a),  32'h3);
`ifdef NIBBLE_ARB_PARITY_EN
    check("stall_parity", 32'(par_a), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
